// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// Sequential RV32I ALU front-end: decodes OP/OP-IMM/BRANCH, drives an external ALU and returns results
// through a valid/ready port. Define ALU_SEQ_B2B_EN to let RESP hand off and accept in the same cycle.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  Upr_ALU,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] Out_ALU,
  input  logic        C,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_we,
  output logic        br_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLTS = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_LTS  = 4'd12,
    ALU_GES  = 4'd13,
    ALU_LTU  = 4'd14,
    ALU_GEU  = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_f     = instr[11:7];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign is_shift = (funct3[1:0] == 2'b01);

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLTS;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // decoded view of the offered instruction
  alu_op_e     dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        dec_br;
  logic        dec_ill;

  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_rd  = '0;
    dec_we  = 1'b0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) begin
          dec_ill = 1'b1;
        end else begin
          dec_op = arith_op(funct3, funct7[5]);
          dec_a  = rs1_data;
          dec_b  = is_shift ? {27'b0, rs2_data[4:0]} : rs2_data;
          dec_rd = rd_f;
          dec_we = (rd_f != 5'd0);
        end
      end
      OPC_OP_IMM: begin
        dec_op = arith_op(funct3, (funct3 == 3'b101) && instr[30]);
        dec_a  = rs1_data;
        dec_b  = is_shift ? {27'b0, instr[24:20]} : imm_i;
        dec_rd = rd_f;
        dec_we = (rd_f != 5'd0);
      end
      OPC_BRANCH: begin
        dec_a  = rs1_data;
        dec_b  = rs2_data;
        dec_br = 1'b1;
        case (funct3)
          3'b000:  dec_op = ALU_EQ;
          3'b001:  dec_op = ALU_NE;
          3'b100:  dec_op = ALU_LTS;
          3'b101:  dec_op = ALU_GES;
          3'b110:  dec_op = ALU_LTU;
          3'b111:  dec_op = ALU_GEU;
          default: begin
            dec_ill = 1'b1;
            dec_a   = '0;
            dec_b   = '0;
            dec_br  = 1'b0;
          end
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  state_e      state_q,    state_d;
  alu_op_e     upr_q,      upr_d;
  logic [31:0] a_q,        a_d;
  logic [31:0] b_q,        b_d;
  logic        is_br_q,    is_br_d;
  logic [31:0] res_data_q, res_data_d;
  logic [4:0]  res_rd_q,   res_rd_d;
  logic        res_we_q,   res_we_d;
  logic        br_q,       br_d;
  logic        ill_q,      ill_d;
  logic        accept;

`ifdef ALU_SEQ_B2B_EN
  assign instr_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && res_ready);
`else
  assign instr_ready = (state_q == S_IDLE);
`endif

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    upr_d      = upr_q;
    a_d        = a_q;
    b_d        = b_q;
    is_br_d    = is_br_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_we_d   = res_we_q;
    br_d       = br_q;
    ill_d      = ill_q;
    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        res_data_d = is_br_q ? '0 : Out_ALU;
        br_d       = is_br_q ? C : 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a new accept overrides the RESP->IDLE handoff when back-to-back issue is enabled
    if (accept) begin
      upr_d      = dec_op;
      a_d        = dec_a;
      b_d        = dec_b;
      is_br_d    = dec_br;
      res_data_d = '0;
      res_rd_d   = dec_rd;
      res_we_d   = dec_we;
      br_d       = 1'b0;
      ill_d      = dec_ill;
      state_d    = dec_ill ? S_RESP : S_EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      upr_q      <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      is_br_q    <= 1'b0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
      br_q       <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      upr_q      <= upr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      is_br_q    <= is_br_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_we_q   <= res_we_d;
      br_q       <= br_d;
      ill_q      <= ill_d;
    end
  end

  assign Upr_ALU   = upr_q;
  assign A         = a_q;
  assign B         = b_q;
  assign res_valid = (state_q == S_RESP);
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_we    = res_we_q;
  assign br_taken  = br_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Bench for alu_seq: directed vector table, randomized instructions against an ISA-level model,
// backpressure/reset corners and a streaming throughput check.
module tb_alu_seq;

`ifdef ALU_SEQ_B2B_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [3:0]  Upr_ALU;
  logic [31:0] A, B;
  logic [31:0] Out_ALU;
  logic        C;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we, br_taken, illegal;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .Upr_ALU(Upr_ALU), .A(A), .B(B), .Out_ALU(Out_ALU), .C(C),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_we(res_we),
    .br_taken(br_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // external ALU
  always_comb begin
    Out_ALU = '0;
    C       = 1'b0;
    case (Upr_ALU)
      4'd0:  Out_ALU = A + B;
      4'd1:  Out_ALU = A - B;
      4'd2:  Out_ALU = A << B[4:0];
      4'd3:  Out_ALU = {31'b0, $signed(A) < $signed(B)};
      4'd4:  Out_ALU = {31'b0, A < B};
      4'd5:  Out_ALU = A ^ B;
      4'd6:  Out_ALU = A >> B[4:0];
      4'd7:  Out_ALU = $signed(A) >>> B[4:0];
      4'd8:  Out_ALU = A | B;
      4'd9:  Out_ALU = A & B;
      4'd10: C = (A == B);
      4'd11: C = (A != B);
      4'd12: C = ($signed(A) < $signed(B));
      4'd13: C = ($signed(A) >= $signed(B));
      4'd14: C = (A < B);
      default: C = (A >= B);
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } res_t;

  // architectural result of one instruction
  function automatic res_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [31:0] op2;
    int unsigned sh;
    logic alt, imm;
    r.data = '0; r.rd = '0; r.we = 1'b0; r.br = 1'b0; r.ill = 1'b0;
    imm = (ins[6:0] == 7'h13);
    if (ins[6:0] == 7'h33 || imm) begin
      if (!imm && ins[31:25] != 7'h00 && ins[31:25] != 7'h20) begin
        r.ill = 1'b1;
      end else begin
        op2 = imm ? {{20{ins[31]}}, ins[31:20]} : b;
        sh  = imm ? ins[24:20] : b[4:0];
        alt = ins[30];
        case (ins[14:12])
          3'd0: r.data = (!imm && alt) ? a - op2 : a + op2;
          3'd1: r.data = a << sh;
          3'd2: r.data = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
          3'd3: r.data = (a < op2) ? 32'd1 : 32'd0;
          3'd4: r.data = a ^ op2;
          3'd5: r.data = alt ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: r.data = a | op2;
          default: r.data = a & op2;
        endcase
        r.rd = ins[11:7];
        r.we = (ins[11:7] != 5'd0);
      end
    end else if (ins[6:0] == 7'h63) begin
      case (ins[14:12])
        3'd0: r.br = (a == b);
        3'd1: r.br = (a != b);
        3'd4: r.br = ($signed(a) < $signed(b));
        3'd5: r.br = ($signed(a) >= $signed(b));
        3'd6: r.br = (a < b);
        3'd7: r.br = (a >= b);
        default: r.ill = 1'b1;
      endcase
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // observations from the last transaction
  logic [31:0] o_upr, o_b, o_data;
  logic [4:0]  o_rd;
  logic        o_we, o_br, o_ill, o_valid;
  int          o_lat;

  task automatic run_txn(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input int hold);
    instr_valid = 1'b1; instr = ins; rs1_data = r1; rs2_data = r2;
    @(posedge clk); #1;
    // offer junk while the block is busy; it must not be latched
    instr_valid = !res_valid;
    instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    o_upr = {28'b0, Upr_ALU}; o_b = B; o_lat = 1;
    while (!res_valid && o_lat < 8) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      o_lat++;
    end
    instr_valid = 1'b0;
    for (int k = 0; k < hold; k++) begin @(posedge clk); #1; end
    o_valid = res_valid; o_data = res_data; o_rd = res_rd;
    o_we = res_we; o_br = br_taken; o_ill = illegal;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins, r1, r2;
    logic        chk_ab;
    logic [3:0]  upr;
    logic [31:0] b, data;
    logic [4:0]  rd;
    logic        we, br, ill;
    int          lat;
  } vec_t;

  vec_t vt[14];
  res_t m;
  logic [31:0] ins_r, r1_r, r2_r;
  logic [31:0] sq_ins[4];
  int t_res[4];
  int idx, got, cyc;
  logic acc, rv;
  logic [31:0] sd;
  logic [4:0] srd;

  initial begin
    vt[0]  = '{32'h002082B3, 32'd7,        32'hFFFFFFFF, 1'b1, 4'd0,  32'hFFFFFFFF, 32'd6,        5'd5,  1'b1, 1'b0, 1'b0, 2};
    vt[1]  = '{32'h40425193, 32'h80000000, 32'd0,        1'b1, 4'd7,  32'd4,        32'hF8000000, 5'd3,  1'b1, 1'b0, 1'b0, 2};
    vt[2]  = '{32'h00839333, 32'd1,        32'h00000123, 1'b1, 4'd2,  32'd3,        32'd8,        5'd6,  1'b1, 1'b0, 1'b0, 2};
    vt[3]  = '{32'h0020E063, 32'd1,        32'hFFFFFFFF, 1'b1, 4'd14, 32'hFFFFFFFF, 32'd0,        5'd0,  1'b0, 1'b1, 1'b0, 2};
    vt[4]  = '{32'h0020D063, 32'hFFFFFFFF, 32'd0,        1'b1, 4'd13, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 2};
    vt[5]  = '{32'h0000007F, 32'd1,        32'd2,        1'b0, 4'd0,  32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b1, 1};
    vt[6]  = '{32'h00108013, 32'd5,        32'd0,        1'b1, 4'd0,  32'd1,        32'd6,        5'd0,  1'b0, 1'b0, 1'b0, 2};
    vt[7]  = '{32'h40C58533, 32'd5,        32'd7,        1'b1, 4'd1,  32'd7,        32'hFFFFFFFE, 5'd10, 1'b1, 1'b0, 1'b0, 2};
    vt[8]  = '{32'h02000033, 32'd3,        32'd4,        1'b0, 4'd0,  32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b1, 1};
    vt[9]  = '{32'h00002063, 32'd3,        32'd3,        1'b0, 4'd0,  32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 1'b1, 1};
    vt[10] = '{32'hFFF08093, 32'd10,       32'd0,        1'b1, 4'd0,  32'hFFFFFFFF, 32'd9,        5'd1,  1'b1, 1'b0, 1'b0, 2};
    vt[11] = '{32'h003120B3, 32'hFFFFFFFF, 32'd1,        1'b1, 4'd3,  32'd1,        32'd1,        5'd1,  1'b1, 1'b0, 1'b0, 2};
    vt[12] = '{32'h003150B3, 32'h80000000, 32'h00000024, 1'b1, 4'd6,  32'd4,        32'h08000000, 5'd1,  1'b1, 1'b0, 1'b0, 2};
    vt[13] = '{32'h00209063, 32'd3,        32'd4,        1'b1, 4'd11, 32'd4,        32'd0,        5'd0,  1'b0, 1'b1, 1'b0, 2};

    // reset state
    #3;
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_upr", {28'b0, Upr_ALU}, 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_misc", {24'b0, res_rd, res_we, br_taken, illegal}, 32'd0);
    check("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 14; i++) begin
      check($sformatf("v%0d_ready", i), {31'b0, instr_ready}, 32'd1);
      run_txn(vt[i].ins, vt[i].r1, vt[i].r2, 0);
      check($sformatf("v%0d_lat", i), o_lat, vt[i].lat);
      check($sformatf("v%0d_data", i), o_data, vt[i].data);
      check($sformatf("v%0d_rd", i), {27'b0, o_rd}, {27'b0, vt[i].rd});
      check($sformatf("v%0d_we", i), {31'b0, o_we}, {31'b0, vt[i].we});
      check($sformatf("v%0d_br", i), {31'b0, o_br}, {31'b0, vt[i].br});
      check($sformatf("v%0d_ill", i), {31'b0, o_ill}, {31'b0, vt[i].ill});
      if (vt[i].chk_ab) begin
        check($sformatf("v%0d_upr", i), o_upr, {28'b0, vt[i].upr});
        check($sformatf("v%0d_B", i), o_b, vt[i].b);
      end
    end

    // randomized instructions
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      ins_r = $urandom;
      if (sel <= 2) begin
        ins_r[6:0] = 7'h33;
        if ($urandom_range(0, 7) != 0) ins_r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end else if (sel <= 4) begin
        ins_r[6:0] = 7'h13;
      end else if (sel <= 6) begin
        ins_r[6:0] = 7'h63;
      end
      if ($urandom_range(0, 7) == 0) ins_r[11:7] = 5'd0;
      r1_r = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      r2_r = $urandom_range(0, 3) == 0 ? r1_r : $urandom;
      m = model(ins_r, r1_r, r2_r);
      run_txn(ins_r, r1_r, r2_r, $urandom_range(0, 2));
      check($sformatf("r%0d_lat", i), o_lat, m.ill ? 32'd1 : 32'd2);
      check($sformatf("r%0d_data", i), o_data, m.data);
      check($sformatf("r%0d_rd", i), {27'b0, o_rd}, {27'b0, m.rd});
      check($sformatf("r%0d_flags", i), {29'b0, o_we, o_br, o_ill}, {29'b0, m.we, m.br, m.ill});
    end

    // backpressure then reset while in RESP
    instr_valid = 1'b1; instr = vt[0].ins; rs1_data = vt[0].r1; rs2_data = vt[0].r2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), {31'b0, res_valid}, 32'd1);
      check($sformatf("bp%0d_ready", k), {31'b0, instr_ready}, 32'd0);
      check($sformatf("bp%0d_data", k), res_data, 32'd6);
      check($sformatf("bp%0d_rdwe", k), {26'b0, res_rd, res_we}, {26'b0, 5'd5, 1'b1});
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rsp_rst_valid", {31'b0, res_valid}, 32'd0);
    check("rsp_rst_data", res_data, 32'd0);
    check("rsp_rst_AB", A | B, 32'd0);
    check("rsp_rst_misc", {23'b0, Upr_ALU, res_rd}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("rsp_rst_ready", {31'b0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    run_txn(vt[1].ins, vt[1].r1, vt[1].r2, 0);
    check("post_rst_data", o_data, 32'hF8000000);
    check("post_rst_lat", o_lat, 32'd2);

    // reset while in EXEC aborts the operation
    instr_valid = 1'b1; instr = vt[0].ins; rs1_data = vt[0].r1; rs2_data = vt[0].r2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort%0d_valid", k), {31'b0, res_valid}, 32'd0);
      check($sformatf("abort%0d_ready", k), {31'b0, instr_ready}, 32'd1);
    end

    // streaming throughput
    for (int k = 0; k < 4; k++)
      sq_ins[k] = ((k * 3 + 1) << 20) | (1 << 15) | ((k + 1) << 7) | 32'h13;
    instr = sq_ins[0]; rs1_data = 32'd100; rs2_data = '0;
    instr_valid = 1'b1; res_ready = 1'b1;
    idx = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      acc = instr_valid && instr_ready;
      rv = res_valid; sd = res_data; srd = res_rd;
      @(posedge clk); #1;
      cyc++;
      if (rv) begin
        check($sformatf("st%0d_data", got), sd, 32'd100 + got * 3 + 1);
        check($sformatf("st%0d_rd", got), {27'b0, srd}, got + 1);
        t_res[got] = cyc;
        got++;
      end
      if (acc) begin
        idx++;
        if (idx < 4) instr = sq_ins[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0; res_ready = 1'b0;
    check("st_count", got, 32'd4);
    for (int k = 1; k < 4; k++)
      check($sformatf("st%0d_spacing", k), t_res[k] - t_res[k-1], SPACING);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with the ports listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr_valid  in  1  instruction word plus operands offered.
REQ-005 instr_ready  out  1  block can accept an instruction.
REQ-006 instr  in  32  RV32I instruction word.
REQ-007 rs1_data, rs2_data  in  32 each  register operands for instr.
REQ-008 Upr_ALU  out  4  ALU opcode: ADD=0, SUB=1, SLL=2, SLTS=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, EQ=10, NE=11, LTS=12, GES=13, LTU=14, GEU=15.
REQ-009 A, B  out  32 each  ALU operands.
REQ-010 Out_ALU  in  32  ALU result; C  in  1  ALU compare flag.
REQ-011 res_valid  out  1  result offered; res_ready  in  1  consumer accepts the result.
REQ-012 res_data  out  32; res_rd  out  5; res_we  out  1; br_taken  out  1; illegal  out  1.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP; instr_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, when instr_valid=1, the block SHALL register Upr_ALU, A, B, rd and the instruction class on that edge, then move to EXEC; an illegal instruction SHALL go directly to RESP.
REQ-015 In EXEC, the block SHALL hold Upr_ALU, A and B stable for exactly one cycle, then capture Out_ALU into res_data and C into br_taken at the end of that cycle, and move to RESP.
REQ-016 In RESP, res_valid SHALL be 1 and all res_* outputs SHALL be stable until res_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-017 Latency: for an instruction accepted at edge N, res_valid SHALL be high from cycle N+2 (N+1 for an illegal instruction).
REQ-018 OP (0110011): funct3 000 SHALL map to ADD, or to SUB when funct7=0100000; 001 to SLL; 010 to SLTS; 011 to SLTU; 100 to XOR; 101 to SRL, or to SRA when funct7=0100000; 110 to OR; 111 to AND. A=rs1_data; B=rs2_data, except that for shifts B={27'b0,rs2_data[4:0]}.
REQ-019 OP-IMM (0010011): the mapping SHALL be the same as OP, except that funct3 000 is always ADD and SRA is selected by instr[30]. B SHALL be sign-extended instr[31:20]; for shifts B={27'b0,instr[24:20]}.
REQ-020 BRANCH (1100011): funct3 000 SHALL map to EQ, 001 to NE, 100 to LTS, 101 to GES, 110 to LTU and 111 to GEU. A=rs1_data; B=rs2_data; res_we=0; res_data=0; br_taken=C.
REQ-021 Illegal encodings SHALL be: any other opcode, BRANCH funct3 010/011, and OP funct7 not in {0000000, 0100000}. For these, illegal=1, res_we=0, res_data=0 and br_taken=0.
REQ-022 For OP/OP-IMM, res_we SHALL be 1 unless rd=0, and res_rd SHALL be instr[11:7]; for BRANCH and illegal instructions, res_rd=0.
REQ-023 instr_valid asserted outside IDLE SHALL be ignored, and the offered values SHALL NOT be latched.

Reset
REQ-024 On rst_n=0, asynchronously: the FSM SHALL go to IDLE, and Upr_ALU, A, B, res_data, res_rd, res_we, br_taken, illegal and res_valid SHALL be 0.
REQ-025 Reset asserted in EXEC or RESP SHALL abort the operation with no result delivered; instr_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-026 Macro ALU_SEQ_B2B_EN, when defined: in RESP, instr_ready SHALL equal res_ready, and a simultaneous result handoff plus new accept SHALL go directly to EXEC (or to RESP if illegal). Sustained throughput SHALL be one instruction per 2 cycles.
REQ-027 Without ALU_SEQ_B2B_EN, instr_ready SHALL be 0 in RESP and throughput SHALL be at most one instruction per 3 cycles.

Verification
REQ-028 ADD x5,x1,x2 with rs1=7, rs2=0xFFFFFFFF and the ALU model connected -> Upr_ALU=0 in EXEC; res_data=6, res_rd=5, res_we=1, res_valid at accept+2.
REQ-029 SRAI x3,x4,4 with rs1=0x80000000 -> Upr_ALU=7, B=4; res_data=0xF8000000. SLL with rs2=0x00000123 -> B=3.
REQ-030 BLTU with rs1=1, rs2=0xFFFFFFFF -> Upr_ALU=14, br_taken=1, res_we=0. BGE with rs1=-1, rs2=0 -> Upr_ALU=13, br_taken=0.
REQ-031 Illegal case: instr=0x0000007F -> res_valid at accept+1, illegal=1, res_we=0. ADDI x0,x1,1 -> res_we=0.
REQ-032 Backpressure: hold res_ready=0 for 5 cycles -> res_* stable and instr_ready=0. Then pulse rst_n low while in RESP -> res_valid=0 immediately, and the next instruction is accepted normally.
REQ-033 With ALU_SEQ_B2B_EN: stream 4 instructions with res_ready=1 -> the 4 results arrive at 2-cycle spacing in order. Without the macro -> 3-cycle spacing.
